// File: rtl/conv_read_ctrl_if.sv
// Byte bus between the convolution read controller and the
// read/write buffers of the memory port.
interface conv_read_ctrl_if;
    logic [31:0] address;
    logic        rdwr_cntl;
    logic        n_action;
    logic        user_data_available;
    logic        user_buffer_full;
    logic        user_read_buffer;
    logic        user_write_buffer;
    logic [2:0]  address_select;

    modport master (
        output address,
        output rdwr_cntl,
        output n_action,
        output user_read_buffer,
        output user_write_buffer,
        output address_select,
        input  user_data_available,
        input  user_buffer_full
    );

    modport slave (
        input  address,
        input  rdwr_cntl,
        input  n_action,
        input  user_read_buffer,
        input  user_write_buffer,
        input  address_select,
        output user_data_available,
        output user_buffer_full
    );
endinterface

// File: rtl/conv_read_ctrl.sv
// Read/write sequencer for a 3x3 convolution pass: header load,
// row priming, one column per pixel, write-back and advance.
module conv_read_ctrl #(
    parameter int unsigned HDR_BYTES = 8,
    parameter logic [31:0] WR_BASE   = 32'h0010_0000,
    parameter int unsigned ROW_COLS  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    conv_read_ctrl_if.master        bus,
    input  logic                    i_start,
    input  logic                    i_image_done,
    input  logic [31:0]             i_mid_addr,
    input  logic [31:0]             i_bot_addr,
    output logic                    o_buffer_load,
    output logic                    o_load_size,
    output logic                    o_count_enable,
    output logic                    o_flag_clear,
    output logic                    o_output_load,
    output logic                    o_data_select,
    output logic                    o_idle_out,
    output logic                    o_read_state
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_REQ,
        S_HDR_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_CALC,
        S_WR_WAIT,
        S_WR_REQ,
        S_ADVANCE,
        S_DONE
    } state_t;

    localparam logic [2:0] SEL_TOP = 3'd0;
    localparam logic [2:0] SEL_WR  = 3'd3;
    localparam logic [2:0] SEL_HDR = 3'd4;

    state_t      r_state;
    logic [31:0] r_hdr_ptr;
    logic [31:0] r_top_ptr;
    logic [31:0] r_mid_ptr;
    logic [31:0] r_bot_ptr;
    logic [31:0] r_wr_ptr;
    logic [1:0]  r_row;
    logic [3:0]  r_byte_cnt;
    logic        r_prime;
    logic [15:0] r_col;

    logic [31:0] r_address;
    logic        r_rdwr;
    logic        r_n_action;
    logic [2:0]  r_addr_sel;
    logic        r_user_write;
    logic        r_flag_clear;
    logic        r_output_load;
    logic        r_data_select;
    logic        r_count_enable;
    logic        r_idle;
    logic        r_read_state;

    logic        w_hdr_acc;
    logic        w_rd_acc;
    logic        w_last_byte;
    logic [1:0]  w_nrow;
    logic [31:0] w_nrow_addr;

    // Accept strobes follow the byte-valid input directly so the byte is
    // taken in the cycle it is offered; reset abandons any such accept.
    assign w_hdr_acc = (r_state == S_HDR_WAIT)
                     && bus.user_data_available && !i_rst;
    assign w_rd_acc  = (r_state == S_RD_WAIT)
                     && bus.user_data_available && !i_rst;

    assign w_last_byte = (r_byte_cnt == (r_prime ? 4'd8 : 4'd2));

    always_comb begin
        w_nrow      = (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
        w_nrow_addr = r_bot_ptr;
        if (w_nrow == 2'd0)
            w_nrow_addr = r_top_ptr;
        else if (w_nrow == 2'd1)
            w_nrow_addr = r_mid_ptr;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_hdr_ptr      <= '0;
            r_top_ptr      <= '0;
            r_mid_ptr      <= '0;
            r_bot_ptr      <= '0;
            r_wr_ptr       <= WR_BASE;
            r_row          <= '0;
            r_byte_cnt     <= '0;
            r_prime        <= 1'b1;
            r_col          <= '0;
            r_address      <= '0;
            r_rdwr         <= 1'b1;
            r_n_action     <= 1'b1;
            r_addr_sel     <= SEL_TOP;
            r_user_write   <= 1'b0;
            r_flag_clear   <= 1'b0;
            r_output_load  <= 1'b0;
            r_data_select  <= 1'b0;
            r_count_enable <= 1'b0;
            r_idle         <= 1'b1;
            r_read_state   <= 1'b0;
        end else begin
            r_n_action     <= 1'b1;
            r_user_write   <= 1'b0;
            r_flag_clear   <= 1'b0;
            r_output_load  <= 1'b0;
            r_data_select  <= 1'b0;
            r_count_enable <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_HDR_REQ;
                        r_hdr_ptr    <= '0;
                        r_wr_ptr     <= WR_BASE;
                        r_col        <= '0;
                        r_prime      <= 1'b1;
                        r_idle       <= 1'b0;
                        r_read_state <= 1'b1;
                        r_address    <= '0;
                        r_addr_sel   <= SEL_HDR;
                        r_rdwr       <= 1'b1;
                        r_n_action   <= 1'b0;
                    end
                end

                S_HDR_REQ: r_state <= S_HDR_WAIT;

                S_HDR_WAIT: begin
                    if (w_hdr_acc) begin
                        r_hdr_ptr  <= r_hdr_ptr + 32'd1;
                        r_n_action <= 1'b0;
                        r_rdwr     <= 1'b1;
                        if (r_hdr_ptr == 32'(HDR_BYTES - 1)) begin
                            r_state      <= S_RD_REQ;
                            r_flag_clear <= 1'b1;
                            r_top_ptr    <= '0;
                            r_mid_ptr    <= i_mid_addr;
                            r_bot_ptr    <= i_bot_addr;
                            r_row        <= 2'd0;
                            r_byte_cnt   <= '0;
                            r_address    <= '0;
                            r_addr_sel   <= SEL_TOP;
                        end else begin
                            r_state   <= S_HDR_REQ;
                            r_address <= r_hdr_ptr + 32'd1;
                        end
                    end
                end

                S_RD_REQ: r_state <= S_RD_WAIT;

                S_RD_WAIT: begin
                    if (w_rd_acc) begin
                        unique case (r_row)
                            2'd0:    r_top_ptr <= r_top_ptr + 32'd1;
                            2'd1:    r_mid_ptr <= r_mid_ptr + 32'd1;
                            default: r_bot_ptr <= r_bot_ptr + 32'd1;
                        endcase
                        if (w_last_byte) begin
                            r_state       <= S_CALC;
                            r_prime       <= 1'b0;
                            r_output_load <= 1'b1;
                            r_data_select <= 1'b1;
                            r_read_state  <= 1'b0;
                        end else begin
                            r_state    <= S_RD_REQ;
                            r_byte_cnt <= r_byte_cnt + 4'd1;
                            r_row      <= w_nrow;
                            r_address  <= w_nrow_addr;
                            r_addr_sel <= {1'b0, w_nrow};
                            r_rdwr     <= 1'b1;
                            r_n_action <= 1'b0;
                        end
                    end
                end

                S_CALC: r_state <= S_WR_WAIT;

                S_WR_WAIT: begin
                    if (!bus.user_buffer_full) begin
                        r_state      <= S_WR_REQ;
                        r_address    <= r_wr_ptr;
                        r_addr_sel   <= SEL_WR;
                        r_rdwr       <= 1'b0;
                        r_n_action   <= 1'b0;
                        r_user_write <= 1'b1;
                    end
                end

                S_WR_REQ: begin
                    r_state        <= S_ADVANCE;
                    r_wr_ptr       <= r_wr_ptr + 32'd1;
                    r_count_enable <= 1'b1;
                end

                S_ADVANCE: begin
                    // End of an output row: the next window must be re-primed.
                    if (r_col == 16'(ROW_COLS - 1)) begin
                        r_col   <= '0;
                        r_prime <= 1'b1;
                    end else begin
                        r_col <= r_col + 16'd1;
                    end
                    if (i_image_done) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state      <= S_RD_REQ;
                        r_row        <= 2'd0;
                        r_byte_cnt   <= '0;
                        r_read_state <= 1'b1;
                        r_address    <= r_top_ptr;
                        r_addr_sel   <= SEL_TOP;
                        r_rdwr       <= 1'b1;
                        r_n_action   <= 1'b0;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_idle  <= 1'b1;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.address           = r_address;
    assign bus.rdwr_cntl         = r_rdwr;
    assign bus.n_action          = r_n_action;
    assign bus.address_select    = r_addr_sel;
    assign bus.user_write_buffer = r_user_write;
    assign bus.user_read_buffer  = w_hdr_acc | w_rd_acc;

    assign o_buffer_load  = w_rd_acc;
    assign o_load_size    = w_hdr_acc;
    assign o_count_enable = r_count_enable;
    assign o_flag_clear   = r_flag_clear;
    assign o_output_load  = r_output_load;
    assign o_data_select  = r_data_select;
    assign o_idle_out     = r_idle;
    assign o_read_state   = r_read_state;

endmodule

// File: tb/tb_conv_read_ctrl.sv
// Bench for conv_read_ctrl: byte-level event model of a whole image
// pass, bus responder, backpressure and mid-read reset.
module tb_conv_read_ctrl;
  localparam logic [31:0] WR_BASE = 32'h0010_0000;
  localparam int HDR = 8;
  localparam int COLS = 4;
  localparam int WAITC = 1;
  localparam int BP_PIX = 1;

  localparam int EV_LS = 0;
  localparam int EV_BL = 1;
  localparam int EV_FC = 2;
  localparam int EV_RD = 3;
  localparam int EV_WR = 4;
  localparam int EV_OL = 5;
  localparam int EV_CE = 6;

  typedef struct {
    int kind;
    logic [2:0] sel;
    logic [31:0] addr;
  } ev_t;

  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic image_done = 0;
  logic [31:0] mid_addr = 0;
  logic [31:0] bot_addr = 0;
  logic avail = 0;
  logic full = 0;
  logic stray = 0;
  logic buffer_load, load_size, count_enable, flag_clear;
  logic output_load, data_select, idle_out, read_state;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int npix_target = 0;
  int rel_cyc = -100;
  int ls_total = 0;
  int fc_total = 0;
  int bl_total = 0;
  int ce_total = 0;
  ev_t exp_q[$];
  logic [31:0] hdr_log[$];
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];
  int wr_cyc[$];

  conv_read_ctrl_if bus();

  assign bus.user_data_available = avail;
  assign bus.user_buffer_full = full;

  conv_read_ctrl #(
    .HDR_BYTES(HDR),
    .WR_BASE(WR_BASE),
    .ROW_COLS(COLS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus),
    .i_start(start),
    .i_image_done(image_done),
    .i_mid_addr(mid_addr),
    .i_bot_addr(bot_addr),
    .o_buffer_load(buffer_load),
    .o_load_size(load_size),
    .o_count_enable(count_enable),
    .o_flag_clear(flag_clear),
    .o_output_load(output_load),
    .o_data_select(data_select),
    .o_idle_out(idle_out),
    .o_read_state(read_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [2:0] s,
                      input logic [31:0] a);
    ev_t e;
    e.kind = k;
    e.sel = s;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  // Whole-pass event list: header bytes, then per output pixel a
  // 3x3 prime at each row start or a single new column otherwise.
  task automatic gen_pass(input logic [31:0] mid, input logic [31:0] bot,
                          input int npix);
    logic [31:0] base[3];
    logic [31:0] off;
    int ngrp;
    base[0] = 0;
    base[1] = mid;
    base[2] = bot;
    off = 0;
    for (int h = 0; h < HDR; h++) begin
      push(EV_RD, 3'd4, 32'(h));
      push(EV_LS, 3'd0, 32'd0);
    end
    push(EV_FC, 3'd0, 32'd0);
    for (int n = 0; n < npix; n++) begin
      ngrp = ((n % COLS) == 0) ? 3 : 1;
      for (int g = 0; g < ngrp; g++) begin
        for (int r = 0; r < 3; r++) begin
          push(EV_RD, 3'(r), base[r] + off);
          push(EV_BL, 3'd0, 32'd0);
        end
        off = off + 1;
      end
      push(EV_OL, 3'd0, 32'd0);
      push(EV_WR, 3'd3, WR_BASE + 32'(n));
      push(EV_CE, 3'd0, 32'd0);
    end
  endtask

  task automatic obs(input int k, input logic [2:0] s,
                     input logic [31:0] a);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL extra_event: got kind %0d addr %0h expected none",
               k, a);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || ((k == EV_RD || k == EV_WR) &&
          (e.sel != s || e.addr != a))) begin
        errors++;
        $display("FAIL event@%0d: got k%0d s%0d a%0h expected k%0d s%0d a%0h",
                 cyc, k, s, a, e.kind, e.sel, e.addr);
      end
    end
  endtask

  // Compare process: mid-cycle sampling of every output.
  initial begin
    logic bad;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        bad = ($countones({buffer_load, load_size, output_load}) > 1)
           || (bus.user_read_buffer !== (buffer_load | load_size))
           || (bus.user_write_buffer !==
               (!bus.n_action && !bus.rdwr_cntl))
           || ((buffer_load | load_size) && !avail)
           || (buffer_load && !bus.n_action)
           || (full && !bus.n_action)
           || (output_load !== data_select);
        chk("strobe_rules", 64'(bad), 64'd0);
        if (load_size) begin
          obs(EV_LS, 3'd0, 32'd0);
          ls_total++;
        end
        if (buffer_load) begin
          obs(EV_BL, 3'd0, 32'd0);
          bl_total++;
        end
        if (flag_clear) begin
          obs(EV_FC, 3'd0, 32'd0);
          fc_total++;
        end
        if (!bus.n_action) begin
          if (bus.rdwr_cntl) begin
            obs(EV_RD, bus.address_select, bus.address);
            if (bus.address_select == 3'd4) hdr_log.push_back(bus.address);
            else rd_log.push_back(bus.address);
          end else begin
            obs(EV_WR, bus.address_select, bus.address);
            wr_log.push_back(bus.address);
            wr_cyc.push_back(cyc);
          end
        end
        if (output_load) obs(EV_OL, 3'd0, 32'd0);
        if (count_enable) begin
          obs(EV_CE, 3'd0, 32'd0);
          ce_total++;
        end
      end
    end
  end

  // Responder: read bytes after WAITC idle wait cycles, backpressure on
  // one pixel, image_done on the last advance.
  initial begin
    int pend = 0;
    bit pact = 0;
    int bp = 0;
    int olc = 0;
    int cec = 0;
    forever begin
      @(posedge clk);
      #1;
      avail = stray;
      image_done = 0;
      if (pact) begin
        if (pend == 0) begin
          avail = 1;
          pact = 0;
        end else begin
          pend--;
        end
      end
      if (!bus.n_action && bus.rdwr_cntl) begin
        pact = 1;
        pend = WAITC;
      end
      if (idle_out) begin
        olc = 0;
        cec = 0;
      end
      if (bp > 0) begin
        bp--;
        if (bp == 0) begin
          full = 0;
          rel_cyc = cyc + 1;
        end
      end else if (output_load) begin
        if (olc == BP_PIX) begin
          full = 1;
          bp = 20;
        end
        olc++;
      end
      if (count_enable) begin
        if (cec == npix_target - 1) image_done = 1;
        cec++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string nm);
    logic [63:0] got;
    got = 64'({bus.address, bus.rdwr_cntl, bus.n_action,
               bus.user_read_buffer, bus.user_write_buffer,
               bus.address_select, buffer_load, load_size,
               count_enable, flag_clear, output_load, data_select,
               idle_out, read_state});
    chk(nm, got, 64'({32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0,
                      6'b0, 1'b1, 1'b0}));
  endtask

  task automatic run_to_idle(input string nm);
    int i;
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!idle_out) break;
    end
    chk({nm, "_left_idle"}, 64'(i < 10), 64'd1);
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (idle_out) break;
    end
    chk({nm, "_back_idle"}, 64'(i < 5000), 64'd1);
  endtask

  initial begin
    logic [31:0] prime_exp[12];
    int base;
    int i;
    prime_exp = '{0, 100, 200, 1, 101, 201, 2, 102, 202, 3, 103, 203};

    repeat (3) tick();
    @(negedge clk);
    chk_rst("reset_state");
    tick();
    rst = 0;

    mid_addr = 100;
    bot_addr = 200;
    npix_target = 6;
    gen_pass(32'd100, 32'd200, 6);
    tick();
    start = 1;
    tick();
    start = 0;
    run_to_idle("pass");
    chk("model_drained", 64'(exp_q.size()), 64'd0);
    repeat (5) @(negedge clk);
    chk("idle_after_done", 64'(idle_out), 64'd1);

    for (int h = 0; h < HDR; h++)
      chk("hdr_addr", 64'(hdr_log[h]), 64'(h));
    for (int k = 0; k < 12; k++)
      chk("prime_steady_addr", 64'(rd_log[k]), 64'(prime_exp[k]));
    chk("reprime_top", 64'(rd_log[18]), 64'd6);
    chk("reprime_mid", 64'(rd_log[19]), 64'd106);
    chk("first_write", 64'(wr_log[0]), 64'(WR_BASE));
    chk("last_write", 64'(wr_log[5]), 64'(WR_BASE + 32'd5));
    chk("bp_latency", 64'(wr_cyc[1] - rel_cyc), 64'd1);
    chk("load_size_cnt", 64'(ls_total), 64'd8);
    chk("flag_clear_cnt", 64'(fc_total), 64'd1);
    chk("buffer_load_cnt", 64'(bl_total), 64'd30);
    chk("count_en_cnt", 64'(ce_total), 64'd6);

    npix_target = 100;
    base = rd_log.size();
    gen_pass(32'd100, 32'd200, 100);
    tick();
    start = 1;
    tick();
    start = 0;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rd_log.size() >= base + 5) break;
    end
    chk("reach_rd_wait", 64'(i < 500), 64'd1);
    tick();
    rst = 1;
    stray = 1;
    exp_q.delete();
    tick();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_rst("reset_mid_read");
    end
    tick();
    stray = 0;
    repeat (3) @(negedge clk);
    chk("still_idle", 64'(idle_out), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
